rv32_decode_regfile_ctrl: RTL and testbench
===========================================

Name: rv32_decode_regfile_ctrl

Overview:
- Decode/register stage of the single-cycle (uniciclo) RV32I processor.
- Combines three parts:
  - 32x32 register file.
  - Opcode/funct decoder that produces all datapath control signals.
  - Two 32-bit address adders: PC+4 and PC+immediate.
- Sits between instruction memory/immediate generator (upstream) and ALU/data memory/PC register (downstream).

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; index width is clog2(NREGS).

Ports:
- iCLK  in  1  system clock; all state updates on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iInst  in  32  current instruction word.
- iPC  in  32  current program counter.
- iImm  in  32  sign-extended immediate from the immediate generator.
- iWriteData  in  32  value to write to rd (already muxed by the writeback mux).
- oDado1  out  32  value of rs1 = iInst[19:15].
- oDado2  out  32  value of rs2 = iInst[24:20].
- oPC4  out  32  iPC + 4.
- oPCImm  out  32  iPC + iImm.
- oBranch  out  1  conditional branch (beq).
- oJump  out  1  unconditional jump (jal/jalr).
- oLeMem  out  1  data memory read.
- oEscMem  out  1  data memory write.
- oEscReg  out  1  register write enable (also drives the internal regfile write).
- oMemPraReg  out  3  writeback select: 0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate.
- oULActrl  out  5  ALU operation code.
- oOBULA  out  2  ALU B source: 0 = rs2, 1 = immediate.

Behaviour:
- Reset: when iRST is high at a rising edge of iCLK, all registers clear to 0. No write occurs in that cycle. All outputs are combinational, so none has reset state of its own.
- Regfile reads: combinational and zero-latency. Register x0 always reads 0.
- Regfile write: at the rising edge, when oEscReg=1, iRST=0 and rd (iInst[11:7]) is not 0, iWriteData is stored in rd. Writes to x0 are ignored.
- No write bypass: a read of rd in the same cycle returns the old value; the new value is visible after the edge.
- Adders: 32-bit modulo arithmetic; carry is discarded. Example: iPC=FFFFFFFC gives oPC4=00000000.
- Decode is on opcode iInst[6:0]. Signals not listed for a row are 0.
  - 0110011 R-type: EscReg=1, OBULA=0, MemPraReg=0. ULA comes from funct3/funct7[5]: add/sub, sll, slt, sltu, xor, srl/sra, or, and.
  - 0010011 I-ALU: EscReg=1, OBULA=1, MemPraReg=0. ULA from funct3. funct7[5] is honoured only for shifts (srai).
  - 0000011 lw: EscReg=1, LeMem=1, OBULA=1, MemPraReg=1, ULA=ADD.
  - 0100011 sw: EscMem=1, OBULA=1, ULA=ADD.
  - 1100011 beq: Branch=1, OBULA=0, ULA=SUB.
  - 1101111 jal: Jump=1, EscReg=1, MemPraReg=2.
  - 1100111 jalr: Jump=1, EscReg=1, MemPraReg=2, OBULA=1, ULA=ADD.
  - 0110111 lui: EscReg=1, MemPraReg=3.
  - Any other opcode: all control outputs 0, so there is no architectural side effect.
- ULA codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- When defined, adds input iDispReg (5 bits) and output oDispDado (32 bits). This is a third combinational read port for on-board register monitoring, with the same x0 and no-bypass rules.
- When undefined, those ports do not exist and no extra logic is built.

Decomposition:
- Package rv32_uniciclo_pkg holds:
  - opcode constants;
  - ULA operation codes;
  - MemPraReg and OBULA select encodings;
  - XLEN.
- One natural sub-module: add32_unit, instantiated twice (PC+4 and PC+imm).
- Regfile and decoder stay as always blocks inside the top module.

Test Plan:
- Reset: write all regs, assert iRST one cycle, read x1..x31 -> all 00000000.
- addi x5,x0,7 (00700293) with iWriteData=7 -> EscReg=1, OBULA=1, ULA=0. The following cycle, rs1=x5 reads 00000007.
- Write to x0 (iInst rd=0, iWriteData=DEADBEEF) -> x0 still reads 0.
- sw x5,0(x0) (00502023) -> EscMem=1, EscReg=0, OBULA=1, ULA=0.
- beq (00000463) -> Branch=1, ULA=1. Also: iPC=00000010, iImm=00000008 -> oPCImm=00000018, oPC4=00000014.
- Opcode 1111111 -> every control output 0, and no register changes after the edge.

Source files
------------

// File: rtl/rv32_uniciclo_pkg.sv
// Shared definitions for the single-cycle RV32I core.
// Holds the datapath width, the major opcodes handled by the decoder, ALU (ULA) operation
// codes, writeback select and ALU B-source encodings, plus a funct3/funct7 -> ULA helper.
package rv32_uniciclo_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [4:0] {
    UlaAdd  = 5'd0,
    UlaSub  = 5'd1,
    UlaAnd  = 5'd2,
    UlaOr   = 5'd3,
    UlaXor  = 5'd4,
    UlaSll  = 5'd5,
    UlaSrl  = 5'd6,
    UlaSra  = 5'd7,
    UlaSlt  = 5'd8,
    UlaSltu = 5'd9
  } ula_op_e;

  typedef enum logic [2:0] {
    WbAlu = 3'd0,
    WbMem = 3'd1,
    WbPc4 = 3'd2,
    WbImm = 3'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    SrcBRs2 = 2'd0,
    SrcBImm = 2'd1
  } src_b_sel_e;

  // alt_en selects sub/sra when funct7[5] is set. For I-type the caller clears it on
  // funct3=000 so addi never turns into a subtract.
  function automatic ula_op_e ula_from_funct(input logic [2:0] funct3, input logic alt_en);
    ula_op_e op;
    unique case (funct3)
      3'b000:  op = alt_en ? UlaSub : UlaAdd;
      3'b001:  op = UlaSll;
      3'b010:  op = UlaSlt;
      3'b011:  op = UlaSltu;
      3'b100:  op = UlaXor;
      3'b101:  op = alt_en ? UlaSra : UlaSrl;
      3'b110:  op = UlaOr;
      default: op = UlaAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/add32_unit.sv
// Modulo-2^Width adder used for the PC+4 and PC+immediate address paths.
// Ports: a_i, b_i operands; sum_o = a_i + b_i with the carry-out discarded.
module add32_unit #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/rv32_decode_regfile_ctrl.sv
// Decode/register stage of the single-cycle RV32I core: 32x32 register file, opcode/funct
// decoder producing the datapath controls, and the PC+4 / PC+imm address adders.
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset (clears the register file)
//   iInst, iPC, iImm      instruction word, program counter, sign-extended immediate
//   iWriteData            writeback value stored to rd when oEscReg is set
//   oDado1, oDado2        combinational rs1/rs2 reads (x0 reads 0, no write bypass)
//   oPC4, oPCImm          iPC+4 and iPC+iImm, modulo 2^32
//   oBranch .. oOBULA     decoded control signals
// Optional: define REGFILE_DEBUG_PORT_EN to add iDispReg/oDispDado, a third read port for
// on-board register monitoring.
module rv32_decode_regfile_ctrl #(
  parameter int unsigned XLEN  = rv32_uniciclo_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [31:0]     iInst,
  input  logic [XLEN-1:0] iPC,
  input  logic [XLEN-1:0] iImm,
  input  logic [XLEN-1:0] iWriteData,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [4:0]      iDispReg,
  output logic [XLEN-1:0] oDispDado,
`endif
  output logic [XLEN-1:0] oDado1,
  output logic [XLEN-1:0] oDado2,
  output logic [XLEN-1:0] oPC4,
  output logic [XLEN-1:0] oPCImm,
  output logic            oBranch,
  output logic            oJump,
  output logic            oLeMem,
  output logic            oEscMem,
  output logic            oEscReg,
  output logic [2:0]      oMemPraReg,
  output logic [4:0]      oULActrl,
  output logic [1:0]      oOBULA
);

  import rv32_uniciclo_pkg::*;

  localparam int unsigned IdxW = $clog2(NREGS);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [IdxW-1:0] rs1_idx;
  logic [IdxW-1:0] rs2_idx;
  logic [IdxW-1:0] rd_idx;

  assign opcode    = iInst[6:0];
  assign funct3    = iInst[14:12];
  assign funct7_b5 = iInst[30];
  assign rs1_idx   = iInst[15 +: IdxW];
  assign rs2_idx   = iInst[20 +: IdxW];
  assign rd_idx    = iInst[7 +: IdxW];

  logic unused_inst;
  assign unused_inst = ^{iInst[31], iInst[29:25]};

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  ula_op_e    ula_op;
  wb_sel_e    wb_sel;
  src_b_sel_e src_b_sel;
  logic       branch, jump, le_mem, esc_mem, esc_reg;

  always_comb begin
    ula_op    = UlaAdd;
    wb_sel    = WbAlu;
    src_b_sel = SrcBRs2;
    branch    = 1'b0;
    jump      = 1'b0;
    le_mem    = 1'b0;
    esc_mem   = 1'b0;
    esc_reg   = 1'b0;
    unique case (opcode)
      OpRType: begin
        esc_reg = 1'b1;
        ula_op  = ula_from_funct(funct3, funct7_b5);
      end
      OpIAlu: begin
        esc_reg   = 1'b1;
        src_b_sel = SrcBImm;
        // Only srai uses funct7[5]; for other I-ops those bits belong to the immediate.
        ula_op    = ula_from_funct(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OpLoad: begin
        esc_reg   = 1'b1;
        le_mem    = 1'b1;
        src_b_sel = SrcBImm;
        wb_sel    = WbMem;
      end
      OpStore: begin
        esc_mem   = 1'b1;
        src_b_sel = SrcBImm;
      end
      OpBranch: begin
        branch = 1'b1;
        ula_op = UlaSub;
      end
      OpJal: begin
        jump    = 1'b1;
        esc_reg = 1'b1;
        wb_sel  = WbPc4;
      end
      OpJalr: begin
        jump      = 1'b1;
        esc_reg   = 1'b1;
        wb_sel    = WbPc4;
        src_b_sel = SrcBImm;
      end
      OpLui: begin
        esc_reg = 1'b1;
        wb_sel  = WbImm;
      end
      default: ;
    endcase
  end

  assign oBranch    = branch;
  assign oJump      = jump;
  assign oLeMem     = le_mem;
  assign oEscMem    = esc_mem;
  assign oEscReg    = esc_reg;
  assign oMemPraReg = wb_sel;
  assign oULActrl   = ula_op;
  assign oOBULA     = src_b_sel;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (esc_reg && (rd_idx != '0)) begin
      regs_d[rd_idx] = iWriteData;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come straight from the flops, so a same-cycle write is not visible yet.
  assign oDado1 = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
  assign oDado2 = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];

`ifdef REGFILE_DEBUG_PORT_EN
  logic [IdxW-1:0] disp_idx;
  assign disp_idx  = iDispReg[IdxW-1:0];
  assign oDispDado = (disp_idx == '0) ? '0 : regs_q[disp_idx];
`endif

  // ---------------------------------------------------------------------------
  // Address adders
  // ---------------------------------------------------------------------------
  add32_unit #(
    .Width(XLEN)
  ) u_add_pc4 (
    .a_i  (iPC),
    .b_i  (XLEN'(4)),
    .sum_o(oPC4)
  );

  add32_unit #(
    .Width(XLEN)
  ) u_add_pc_imm (
    .a_i  (iPC),
    .b_i  (iImm),
    .sum_o(oPCImm)
  );

endmodule

// File: tb/tb_rv32_decode_regfile_ctrl.sv
// Self-checking bench for rv32_decode_regfile_ctrl: directed scenarios followed by random
// instructions, compared against an array-based register model and a mnemonic-level decode
// table.
module tb_rv32_decode_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] inst, pc, imm, wdata;
  logic [31:0] dado1, dado2, pc4, pc_imm;
  logic        branch, jump, le_mem, esc_mem, esc_reg;
  logic [2:0]  mem_pra_reg;
  logic [4:0]  ula_ctrl;
  logic [1:0]  ob_ula;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  disp_reg;
  logic [31:0] disp_dado;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] model_regs [32];

  rv32_decode_regfile_ctrl dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iInst     (inst),
    .iPC       (pc),
    .iImm      (imm),
    .iWriteData(wdata),
`ifdef REGFILE_DEBUG_PORT_EN
    .iDispReg  (disp_reg),
    .oDispDado (disp_dado),
`endif
    .oDado1    (dado1),
    .oDado2    (dado2),
    .oPC4      (pc4),
    .oPCImm    (pc_imm),
    .oBranch   (branch),
    .oJump     (jump),
    .oLeMem    (le_mem),
    .oEscMem   (esc_mem),
    .oEscReg   (esc_reg),
    .oMemPraReg(mem_pra_reg),
    .oULActrl  (ula_ctrl),
    .oOBULA    (ob_ula)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected controls from the instruction's mnemonic. Packed as
  // {branch, jump, le_mem, esc_mem, esc_reg, wb[2:0], ula[4:0], obula[1:0]}.
  function automatic logic [15:0] ref_ctrl(input logic [31:0] in);
    logic [4:0] alu;
    logic [2:0] f3;
    logic       alt;
    f3  = in[14:12];
    alt = in[30];
    case (f3)
      3'd0: alu = 5'd0;                 // add
      3'd1: alu = 5'd5;                 // sll
      3'd2: alu = 5'd8;                 // slt
      3'd3: alu = 5'd9;                 // sltu
      3'd4: alu = 5'd4;                 // xor
      3'd5: alu = alt ? 5'd7 : 5'd6;    // sra / srl
      3'd6: alu = 5'd3;                 // or
      default: alu = 5'd2;              // and
    endcase
    case (in[6:0])
      7'b0110011: begin
        if (f3 == 3'd0 && alt) alu = 5'd1;  // sub
        return {5'b00001, 3'd0, alu, 2'd0};
      end
      7'b0010011: return {5'b00001, 3'd0, alu, 2'd1};
      7'b0000011: return {5'b00101, 3'd1, 5'd0, 2'd1};
      7'b0100011: return {5'b00010, 3'd0, 5'd0, 2'd1};
      7'b1100011: return {5'b10000, 3'd0, 5'd1, 2'd0};
      7'b1101111: return {5'b01001, 3'd2, 5'd0, 2'd0};
      7'b1100111: return {5'b01001, 3'd2, 5'd0, 2'd1};
      7'b0110111: return {5'b00001, 3'd3, 5'd0, 2'd0};
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model_regs[idx];
  endfunction

  task automatic apply(input logic [31:0] in, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] wd, input logic r);
    @(negedge clk);
    inst  = in;
    pc    = p;
    imm   = im;
    wdata = wd;
    rst   = r;
    #1;
  endtask

  // Clock edge plus the matching model update.
  task automatic commit();
    logic [15:0] c;
    c = ref_ctrl(inst);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end else if (c[10] && inst[11:7] != 5'd0) begin
      model_regs[inst[11:7]] = wdata;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] c;
    logic [15:0] got;
    c   = ref_ctrl(inst);
    got = {branch, jump, le_mem, esc_mem, esc_reg, mem_pra_reg, ula_ctrl, ob_ula};
    check_eq({tag, "_ctrl"}, {16'h0, got}, {16'h0, c});
    check_eq({tag, "_rs1"}, dado1, ref_read(inst[19:15]));
    check_eq({tag, "_rs2"}, dado2, ref_read(inst[24:20]));
    check_eq({tag, "_pc4"}, pc4, pc + 32'd4);
    check_eq({tag, "_pcimm"}, pc_imm, pc + imm);
`ifdef REGFILE_DEBUG_PORT_EN
    check_eq({tag, "_disp"}, disp_dado, ref_read(disp_reg));
`endif
  endtask

  localparam logic [6:0] Opcodes [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                         7'b1111111, 7'b0001111};

  initial begin
    logic [31:0] in;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    inst = 32'h0; pc = 32'h0; imm = 32'h0; wdata = 32'h0; rst = 1'b1;
`ifdef REGFILE_DEBUG_PORT_EN
    disp_reg = 5'd0;
`endif
    apply(32'h0000007f, 32'h0, 32'h0, 32'h0, 1'b1);
    commit();
    apply(32'h0000007f, 32'h0, 32'h0, 32'h0, 1'b1);
    commit();

    // Fill every register, then reset while a write is being requested.
    for (int r = 1; r < 32; r++) begin
      apply({12'h0, 5'd0, 3'd0, 5'(r), 7'b0010011}, 32'h0, 32'h0, $urandom | 32'h1, 1'b0);
      commit();
    end
    apply({20'h0, 5'd31, 7'b0010011}, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("fill_x31_nonzero", {31'h0, dado1 != 32'h0}, 32'h0);  // rs1=x0
    apply({12'h0, 5'd31, 3'd0, 5'd1, 7'b0010011}, 32'h0, 32'h0, 32'h1234, 1'b1);
    commit();
    for (int r = 1; r < 32; r++) begin
      apply({7'h0, 5'(32 - r), 5'(r), 3'd0, 5'd0, 7'b1111111}, 32'h0, 32'h0, 32'h0, 1'b0);
      check_eq($sformatf("reset_x%0d", r), dado1, 32'h0);
    end

    // addi x5,x0,7
    apply(32'h00700293, 32'h0, 32'h7, 32'h7, 1'b0);
    check_eq("addi_escreg", {31'h0, esc_reg}, 32'h1);
    check_eq("addi_obula", {30'h0, ob_ula}, 32'h1);
    check_eq("addi_ula", {27'h0, ula_ctrl}, 32'h0);
    check_eq("addi_nobypass", {27'h0, inst[11:7]} == 32'd5 ? dado1 : 32'h0, 32'h0);
    commit();
    apply({12'h0, 5'd5, 3'd0, 5'd0, 7'b1111111}, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("addi_x5_read", dado1, 32'h7);

    // Write to x0 is dropped.
    apply(32'h00000013, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    commit();
    apply(32'h0000007f, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("x0_stays_zero", dado1, 32'h0);

    // sw x5,0(x0)
    apply(32'h00502023, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("sw_escmem", {31'h0, esc_mem}, 32'h1);
    check_eq("sw_escreg", {31'h0, esc_reg}, 32'h0);
    check_eq("sw_obula", {30'h0, ob_ula}, 32'h1);
    check_eq("sw_ula", {27'h0, ula_ctrl}, 32'h0);
    check_eq("sw_rs2", dado2, 32'h7);
    commit();

    // beq and the adders
    apply(32'h00000463, 32'h00000010, 32'h00000008, 32'h0, 1'b0);
    check_eq("beq_branch", {31'h0, branch}, 32'h1);
    check_eq("beq_ula", {27'h0, ula_ctrl}, 32'h1);
    check_eq("beq_pcimm", pc_imm, 32'h00000018);
    check_eq("beq_pc4", pc4, 32'h00000014);
    commit();
    apply(32'h0000007f, 32'hFFFFFFFC, 32'hFFFFFFF0, 32'h0, 1'b0);
    check_eq("pc4_wrap", pc4, 32'h00000000);
    check_eq("pcimm_wrap", pc_imm, 32'hFFFFFFEC);

    // Illegal opcode: no controls, no register change.
    apply({20'h0, 5'd5, 7'b1111111}, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    check_eq("illegal_ctrl", {16'h0, branch, jump, le_mem, esc_mem, esc_reg, mem_pra_reg,
                              ula_ctrl, ob_ula}, 32'h0);
    commit();
    apply({12'h0, 5'd5, 3'd0, 5'd0, 7'b1111111}, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq("illegal_no_write", dado1, 32'h7);

    // Random instructions against the model.
    for (int n = 0; n < 400; n++) begin
      in = $urandom;
      in[6:0] = Opcodes[$urandom_range(0, 9)];
      apply(in, $urandom, $urandom, $urandom, ($urandom_range(0, 39) == 0));
`ifdef REGFILE_DEBUG_PORT_EN
      disp_reg = 5'($urandom);
      #1;
`endif
      check_all($sformatf("rand%0d", n));
      commit();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
